// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_port_arbiter
// Purpose  : Shares the single AXI4-Lite style request port of the cache
//            between instruction fetch (requester 0) and load/store
//            (requester 1). One transaction is in flight at a time, and every
//            output comes straight from a register.
// Revision : 1.0  initial release
// ============================================================================
module cache_port_arbiter #(
    parameter int FIXED_PRIO = 0       // 0: round-robin on ties, 1: requester 0 wins ties
) (
    input  logic        clk,
    input  logic        rstn,

    // requester side
    input  logic [1:0]  rq_valid,
    output logic [1:0]  rq_ready,
    input  logic [1:0]  rq_we,
    input  logic [63:0] rq_addr,
    input  logic [63:0] rq_wdata,
    input  logic [7:0]  rq_wstrb,
    output logic [1:0]  rs_valid,
    input  logic [1:0]  rs_ready,
    output logic [31:0] rs_rdata,
    output logic        rs_err,

    // cache read channels
    output logic [31:0] c_araddr,
    output logic        c_arvalid,
    input  logic        c_arready,
    input  logic [31:0] c_rdata,
    input  logic [1:0]  c_rresp,
    input  logic        c_rvalid,
    output logic        c_rready,

    // cache write channels
    output logic [31:0] c_awaddr,
    output logic        c_awvalid,
    input  logic        c_awready,
    output logic [31:0] c_wdata,
    output logic [3:0]  c_wstrb,
    output logic        c_wvalid,
    input  logic        c_wready,
    input  logic [1:0]  c_bresp,
    input  logic        c_bvalid,
    output logic        c_bready,

    // status
    output logic        grant,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t r_state;

    // Winner of the current arbitration and the fields it presents
    logic        w_pick;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;

    // Write-side completion as seen at this edge: a channel is finished if
    // it already dropped its valid or it is handshaking right now
    logic        w_aw_done;
    logic        w_w_done;

    // Only the error bit (MSB) of the cache responses is meaningful here
    logic        w_unused_resp_lsb;

    assign w_unused_resp_lsb = c_rresp[0] ^ c_bresp[0];

    // Arbitration: a lone requester wins; on a tie either alternate with the
    // last winner or always favour instruction fetch
    always_comb begin
        w_pick = 1'b0;
        if (rq_valid == 2'b10) begin
            w_pick = 1'b1;
        end else if (rq_valid == 2'b11) begin
            w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~grant;
        end
    end

    // Select the winning requester's request fields
    always_comb begin
        w_we    = w_pick ? rq_we[1]          : rq_we[0];
        w_addr  = w_pick ? rq_addr[63:32]    : rq_addr[31:0];
        w_wdata = w_pick ? rq_wdata[63:32]   : rq_wdata[31:0];
        w_wstrb = w_pick ? rq_wstrb[7:4]     : rq_wstrb[3:0];
    end

    assign w_aw_done = ~c_awvalid | c_awready;
    assign w_w_done  = ~c_wvalid  | c_wready;

    // Transaction sequencer; every port output is a register of this block
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            rq_ready  <= 2'b00;
            rs_valid  <= 2'b00;
            rs_rdata  <= 32'd0;
            rs_err    <= 1'b0;
            c_araddr  <= 32'd0;
            c_arvalid <= 1'b0;
            c_rready  <= 1'b0;
            c_awaddr  <= 32'd0;
            c_awvalid <= 1'b0;
            c_wdata   <= 32'd0;
            c_wstrb   <= 4'd0;
            c_wvalid  <= 1'b0;
            c_bready  <= 1'b0;
            grant     <= 1'b1;       // requester 0 wins the first tie
            busy      <= 1'b0;
        end else begin
            // the accept strobe is a single-cycle pulse
            rq_ready <= 2'b00;

            case (r_state)
                ST_IDLE: begin
                    if (|rq_valid) begin
                        grant    <= w_pick;
                        rq_ready <= w_pick ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        if (w_we) begin
                            c_awaddr  <= w_addr;
                            c_wdata   <= w_wdata;
                            c_wstrb   <= w_wstrb;
                            c_awvalid <= 1'b1;
                            c_wvalid  <= 1'b1;
                            r_state   <= ST_WADDR;
                        end else begin
                            c_araddr  <= w_addr;
                            c_arvalid <= 1'b1;
                            r_state   <= ST_RADDR;
                        end
                    end
                end

                ST_RADDR: begin
                    // the cache only pulses arready, so arvalid is held
                    // for as long as it takes
                    if (c_arready) begin
                        c_arvalid <= 1'b0;
                        c_rready  <= 1'b1;
                        r_state   <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    if (c_rvalid) begin
                        c_rready <= 1'b0;
                        rs_rdata <= c_rdata;
                        rs_err   <= c_rresp[1];
                        rs_valid <= grant ? 2'b10 : 2'b01;
                        r_state  <= ST_RESP;
                    end
                end

                ST_WADDR: begin
                    // address and data channels complete independently,
                    // possibly on the same edge
                    if (c_awready) begin
                        c_awvalid <= 1'b0;
                    end
                    if (c_wready) begin
                        c_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        c_bready <= 1'b1;
                        r_state  <= ST_WRESP;
                    end
                end

                ST_WRESP: begin
                    if (c_bvalid) begin
                        c_bready <= 1'b0;
                        rs_rdata <= 32'd0;
                        rs_err   <= c_bresp[1];
                        rs_valid <= grant ? 2'b10 : 2'b01;
                        r_state  <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // response fields stay frozen until the owner takes them
                    if (rs_ready[grant]) begin
                        rs_valid <= 2'b00;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Read and write requests never overlap on the cache port
    a_no_ar_aw: assert property (@(posedge clk) disable iff (!rstn)
        !(c_arvalid && c_awvalid));

    // Read data and write response are never accepted together
    a_no_r_b: assert property (@(posedge clk) disable iff (!rstn)
        !(c_rready && c_bready));

    // A response is only ever routed to one requester
    a_rs_onehot: assert property (@(posedge clk) disable iff (!rstn)
        rs_valid != 2'b11);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_port_arbiter
// Purpose  : Directed bench for cache_port_arbiter. A cache responder reacts
//            to the request channels; a protocol-level model checks every
//            cycle; directed tests pin the model with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_port_arbiter;

    logic        clk;
    logic        rstn;
    logic [1:0]  rq_valid, rq_we, rs_ready;
    logic [63:0] rq_addr, rq_wdata;
    logic [7:0]  rq_wstrb;
    logic [31:0] c_rdata;
    logic [1:0]  c_rresp, c_bresp;
    logic        c_arready, c_rvalid, c_awready, c_wready, c_bvalid;

    logic [1:0]  rq_ready, rs_valid;
    logic [31:0] rs_rdata, c_araddr, c_awaddr, c_wdata;
    logic        rs_err, c_arvalid, c_rready, c_awvalid, c_wvalid, c_bready, grant, busy;
    logic [3:0]  c_wstrb;

    // second instance with fixed priority, fed by the same stimulus
    logic [1:0]  f_rq_ready, f_rs_valid;
    logic [31:0] f_rs_rdata, f_c_araddr, f_c_awaddr, f_c_wdata;
    logic        f_rs_err, f_c_arvalid, f_c_rready, f_c_awvalid, f_c_wvalid, f_c_bready, f_grant, f_busy;
    logic [3:0]  f_c_wstrb;

    cache_port_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rstn(rstn),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we), .rq_addr(rq_addr),
        .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb), .rs_valid(rs_valid), .rs_ready(rs_ready),
        .rs_rdata(rs_rdata), .rs_err(rs_err),
        .c_araddr(c_araddr), .c_arvalid(c_arvalid), .c_arready(c_arready), .c_rdata(c_rdata),
        .c_rresp(c_rresp), .c_rvalid(c_rvalid), .c_rready(c_rready),
        .c_awaddr(c_awaddr), .c_awvalid(c_awvalid), .c_awready(c_awready), .c_wdata(c_wdata),
        .c_wstrb(c_wstrb), .c_wvalid(c_wvalid), .c_wready(c_wready), .c_bresp(c_bresp),
        .c_bvalid(c_bvalid), .c_bready(c_bready), .grant(grant), .busy(busy)
    );

    cache_port_arbiter #(.FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .rstn(rstn),
        .rq_valid(rq_valid), .rq_ready(f_rq_ready), .rq_we(rq_we), .rq_addr(rq_addr),
        .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb), .rs_valid(f_rs_valid), .rs_ready(rs_ready),
        .rs_rdata(f_rs_rdata), .rs_err(f_rs_err),
        .c_araddr(f_c_araddr), .c_arvalid(f_c_arvalid), .c_arready(c_arready), .c_rdata(c_rdata),
        .c_rresp(c_rresp), .c_rvalid(c_rvalid), .c_rready(f_c_rready),
        .c_awaddr(f_c_awaddr), .c_awvalid(f_c_awvalid), .c_awready(c_awready), .c_wdata(f_c_wdata),
        .c_wstrb(f_c_wstrb), .c_wvalid(f_c_wvalid), .c_wready(c_wready), .c_bresp(c_bresp),
        .c_bvalid(c_bvalid), .c_bready(f_c_bready), .grant(f_grant), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // cache responder configuration
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rd_val = 32'd0;
    logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;

    // observations recorded by the model
    logic        glog0[$];
    logic        glog1[$];
    int          pulse_cnt[2];
    logic [31:0] last_araddr, last_awaddr, last_wdata, last_rsd;
    logic [3:0]  last_wstrb;
    logic [1:0]  last_rsv;
    logic        last_rse;
    logic        seen_split;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Cache responder
    // ------------------------------------------------------------------
    initial begin : cache_model
        int n;
        c_arready = 0; c_rvalid = 0; c_rdata = 0; c_rresp = 0;
        c_awready = 0; c_wready = 0; c_bvalid = 0; c_bresp = 0;
        forever begin
            tick();
            if (rstn && c_arvalid) begin
                repeat (ar_dly) tick();
                c_arready = 1; tick(); c_arready = 0;
                repeat (r_dly) tick();
                c_rvalid = 1; c_rdata = rd_val; c_rresp = rresp_val;
                tick();
                c_rvalid = 0; c_rdata = 0; c_rresp = 0;
            end else if (rstn && c_awvalid) begin
                n = (aw_dly > w_dly) ? aw_dly : w_dly;
                for (int k = 0; k <= n; k++) begin
                    c_awready = (k == aw_dly);
                    c_wready  = (k == w_dly);
                    tick();
                end
                c_awready = 0; c_wready = 0;
                repeat (b_dly) tick();
                c_bvalid = 1; c_bresp = bresp_val;
                tick();
                c_bvalid = 0; c_bresp = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol model: checks each cycle against the previous cycle's view
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]  rq_valid, rq_ready, rq_we;
        logic [63:0] rq_addr, rq_wdata;
        logic [7:0]  rq_wstrb;
        logic [1:0]  rs_valid, rs_ready;
        logic [31:0] rs_rdata;
        logic        rs_err;
        logic [31:0] araddr;
        logic        arvalid, arready, rvalid, rready;
        logic [31:0] rdata;
        logic [1:0]  rresp, bresp;
        logic [31:0] awaddr, wdata;
        logic [3:0]  wstrb;
        logic        awvalid, awready, wvalid, wready, bvalid, bready, grant, busy;
    } snap_t;

    function automatic snap_t take();
        snap_t s;
        s.rq_valid = rq_valid; s.rq_ready = rq_ready; s.rq_we = rq_we;
        s.rq_addr = rq_addr; s.rq_wdata = rq_wdata; s.rq_wstrb = rq_wstrb;
        s.rs_valid = rs_valid; s.rs_ready = rs_ready; s.rs_rdata = rs_rdata; s.rs_err = rs_err;
        s.araddr = c_araddr; s.arvalid = c_arvalid; s.arready = c_arready;
        s.rvalid = c_rvalid; s.rready = c_rready; s.rdata = c_rdata; s.rresp = c_rresp;
        s.bresp = c_bresp; s.awaddr = c_awaddr; s.wdata = c_wdata; s.wstrb = c_wstrb;
        s.awvalid = c_awvalid; s.awready = c_awready; s.wvalid = c_wvalid; s.wready = c_wready;
        s.bvalid = c_bvalid; s.bready = c_bready; s.grant = grant; s.busy = busy;
        return s;
    endfunction

    initial begin : compare
        snap_t p, c;
        bit    pv;
        logic  m_last, m_owner, win;
        logic [31:0] wa;
        pv = 0; m_last = 1; m_owner = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pv = 0; m_last = 1;
                continue;
            end
            c = take();
            if (f_rq_ready != 2'b00) glog1.push_back(f_rq_ready[1]);
            pulse_cnt[0] += int'(c.rq_ready[0]);
            pulse_cnt[1] += int'(c.rq_ready[1]);
            if (c.wvalid && !c.awvalid) seen_split = 1;
            if (pv) begin
                chk("ar_aw_exclusive", c.arvalid & c.awvalid, 0);
                chk("r_b_exclusive", c.rready & c.bready, 0);

                // arbitration
                if (!p.busy && p.rq_valid != 2'b00) begin
                    if (p.rq_valid == 2'b01)      win = 0;
                    else if (p.rq_valid == 2'b10) win = 1;
                    else                          win = ~m_last;
                    m_last = win; m_owner = win;
                    glog0.push_back(c.grant);
                    chk("rq_ready_accept", c.rq_ready, win ? 2'b10 : 2'b01);
                    chk("grant", c.grant, win);
                    chk("busy_accept", c.busy, 1);
                    wa = win ? p.rq_addr[63:32] : p.rq_addr[31:0];
                    if (p.rq_we[win]) begin
                        chk("write_valids", {c.awvalid, c.wvalid, c.arvalid}, 3'b110);
                        chk("awaddr", c.awaddr, wa);
                        chk("wdata", c.wdata, win ? p.rq_wdata[63:32] : p.rq_wdata[31:0]);
                        chk("wstrb", c.wstrb, win ? p.rq_wstrb[7:4] : p.rq_wstrb[3:0]);
                        last_awaddr = c.awaddr; last_wdata = c.wdata; last_wstrb = c.wstrb;
                    end else begin
                        chk("read_valids", {c.awvalid, c.wvalid, c.arvalid}, 3'b001);
                        chk("araddr", c.araddr, wa);
                        last_araddr = c.araddr;
                    end
                end else begin
                    chk("rq_ready_quiet", c.rq_ready, 0);
                    if (!p.busy) chk("busy_idle", c.busy, 0);
                end

                // request channels hold until their ready pulse
                if (p.arvalid) chk("arvalid_hold", c.arvalid, !p.arready);
                if (p.awvalid) chk("awvalid_hold", c.awvalid, !p.awready);
                if (p.wvalid)  chk("wvalid_hold", c.wvalid, !p.wready);
                if (p.arvalid && p.arready) chk("rready_set", c.rready, 1);
                if ((p.awvalid || p.wvalid) && !c.awvalid && !c.wvalid) chk("bready_set", c.bready, 1);
                if (p.rvalid && p.rready) chk("rready_drop", c.rready, 0);
                if (p.bvalid && p.bready) chk("bready_drop", c.bready, 0);

                // responses appear one cycle after the cache responds
                if (p.rvalid && p.rready) begin
                    chk("rs_valid_read", c.rs_valid, m_owner ? 2'b10 : 2'b01);
                    chk("rs_rdata_read", c.rs_rdata, p.rdata);
                    chk("rs_err_read", c.rs_err, p.rresp[1]);
                end
                if (p.bvalid && p.bready) begin
                    chk("rs_valid_write", c.rs_valid, m_owner ? 2'b10 : 2'b01);
                    chk("rs_rdata_write", c.rs_rdata, 0);
                    chk("rs_err_write", c.rs_err, p.bresp[1]);
                end
                if (p.rs_valid == 2'b00 && c.rs_valid != 2'b00) begin
                    last_rsv = c.rs_valid; last_rsd = c.rs_rdata; last_rse = c.rs_err;
                end
                if (p.rs_valid != 2'b00) begin
                    if ((p.rs_valid & p.rs_ready) != 2'b00) begin
                        chk("rs_drop", c.rs_valid, 0);
                        chk("busy_drop", c.busy, 0);
                    end else begin
                        chk("rs_hold", {c.rs_valid, c.rs_rdata, c.rs_err}, {p.rs_valid, p.rs_rdata, p.rs_err});
                        chk("busy_resp", c.busy, 1);
                    end
                end else if (!(p.rvalid && p.rready) && !(p.bvalid && p.bready)) begin
                    chk("rs_quiet", c.rs_valid, 0);
                end
                if (p.busy && p.rs_valid == 2'b00) chk("busy_hold", c.busy, 1);
            end
            p = c;
            pv = 1;
        end
    end

    // ------------------------------------------------------------------
    // Requester helpers
    // ------------------------------------------------------------------
    task automatic start_req(input int idx, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] st);
        rq_addr[idx*32 +: 32]  = addr;
        rq_wdata[idx*32 +: 32] = wd;
        rq_wstrb[idx*4 +: 4]   = st;
        rq_we[idx]             = we;
        rq_valid[idx]          = 1'b1;
    endtask

    task automatic wait_accept(input int idx);
        bit got;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rq_ready[idx]) begin got = 1; break; end
        end
        if (!got) tmo("accept");
        tick();
        rq_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin got = 1; break; end
        end
        if (!got) tmo("idle");
        tick();
    endtask

    task automatic wait_glog(input int n);
        bit got;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (glog0.size() >= n) begin got = 1; break; end
        end
        if (!got) tmo("grant_count");
        tick();
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stim
        int          p0, p1;
        bit          got;
        logic [4:0]  e0, e1;
        rstn = 0; rq_valid = 0; rq_we = 0; rq_addr = 0; rq_wdata = 0; rq_wstrb = 0;
        rs_ready = 2'b11; seen_split = 0;
        repeat (3) tick();

        // reset state
        chk("rst_grant", grant, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rq_ready", rq_ready, 0);
        chk("rst_rs", {rs_valid, rs_rdata, rs_err}, 0);
        chk("rst_cvalids", {c_arvalid, c_awvalid, c_wvalid, c_rready, c_bready}, 0);
        rstn = 1;
        repeat (2) tick();

        // both requesters continuously valid after reset
        ar_dly = 0; r_dly = 0;
        start_req(0, 0, 32'h0000_0100, 0, 0);
        start_req(1, 0, 32'h0000_0200, 0, 0);
        wait_glog(4);
        rq_valid[0] = 0;
        wait_glog(5);
        rq_valid[1] = 0;
        wait_idle();
        e0 = 5'b11010;   // 0,1,0,1 then 1 once requester 0 leaves
        e1 = 5'b10000;   // 0,0,0,0 then 1 once requester 0 leaves
        if (glog0.size() >= 5 && glog1.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("rr_grant%0d", i), glog0[i], e0[i]);
                chk($sformatf("fixed_grant%0d", i), glog1[i], e1[i]);
            end
        end else begin
            tmo("grant_logs");
        end

        // single read from requester 0
        ar_dly = 1; r_dly = 2; rd_val = 32'hDEAD_BEEF; rresp_val = 2'b00;
        p0 = pulse_cnt[0];
        start_req(0, 0, 32'h0000_1040, 0, 0);
        wait_accept(0);
        wait_idle();
        chk("t1_pulses", pulse_cnt[0] - p0, 1);
        chk("t1_araddr", last_araddr, 32'h0000_1040);
        chk("t1_rs_valid", last_rsv, 2'b01);
        chk("t1_rdata", last_rsd, 32'hDEAD_BEEF);
        chk("t1_err", last_rse, 0);

        // single write from requester 1, address accepted two cycles before data
        aw_dly = 0; w_dly = 2; b_dly = 1; bresp_val = 2'b00; seen_split = 0;
        p1 = pulse_cnt[1];
        start_req(1, 1, 32'h0010_0004, 32'h1234_5678, 4'h3);
        wait_accept(1);
        wait_idle();
        chk("t2_pulses", pulse_cnt[1] - p1, 1);
        chk("t2_awaddr", last_awaddr, 32'h0010_0004);
        chk("t2_wdata", last_wdata, 32'h1234_5678);
        chk("t2_wstrb", last_wstrb, 4'h3);
        chk("t2_split_drop", seen_split, 1);
        chk("t2_rs_valid", last_rsv, 2'b10);
        chk("t2_rdata", last_rsd, 0);
        chk("t2_err", last_rse, 0);

        // error response on a read from requester 1, then a clean one
        ar_dly = 0; r_dly = 1; rd_val = 32'hCAFE_F00D; rresp_val = 2'b10;
        start_req(1, 0, 32'h0000_2000, 0, 0);
        wait_accept(1);
        wait_idle();
        chk("t4_rs_valid", last_rsv, 2'b10);
        chk("t4_err", last_rse, 1);
        chk("t4_rdata", last_rsd, 32'hCAFE_F00D);
        rd_val = 32'h0BAD_CAFE; rresp_val = 2'b00;
        start_req(1, 0, 32'h0000_2004, 0, 0);
        wait_accept(1);
        wait_idle();
        chk("t4b_err", last_rse, 0);
        chk("t4b_rdata", last_rsd, 32'h0BAD_CAFE);

        // response back-pressure with a competing request waiting
        rs_ready = 2'b00; rd_val = 32'h55AA_55AA; aw_dly = 1; w_dly = 1; b_dly = 0;
        start_req(0, 0, 32'h0000_3000, 0, 0);
        wait_accept(0);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rs_valid[0]) begin got = 1; break; end
        end
        if (!got) tmo("t5_rs_valid");
        tick();
        start_req(1, 1, 32'h0000_3100, 32'hA5A5_0001, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_rs_valid", rs_valid, 2'b01);
            chk("t5_rdata", rs_rdata, 32'h55AA_55AA);
            chk("t5_busy", busy, 1);
            chk("t5_no_cvalid", {c_arvalid, c_awvalid}, 0);
            chk("t5_no_accept", rq_ready, 0);
        end
        tick();
        rs_ready = 2'b11;
        wait_accept(1);
        wait_idle();
        chk("t5_write_rs", last_rsv, 2'b10);

        // reset while waiting for read data
        ar_dly = 0; r_dly = 8; rd_val = 32'h1111_2222;
        start_req(0, 0, 32'h0000_4000, 0, 0);
        wait_accept(0);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (c_rready) begin got = 1; break; end
        end
        if (!got) tmo("t6_rready");
        tick();
        rstn = 0;
        #1;
        chk("t6_valids", {c_arvalid, c_awvalid, c_wvalid, c_rready, c_bready, rs_valid, rq_ready}, 0);
        chk("t6_grant", grant, 1);
        chk("t6_busy", busy, 0);
        chk("t6_araddr", c_araddr, 0);
        repeat (12) tick();
        rstn = 1;
        tick();
        r_dly = 1; rd_val = 32'h600D_F00D;
        p0 = pulse_cnt[0];
        start_req(0, 0, 32'h0000_5000, 0, 0);
        wait_accept(0);
        wait_idle();
        chk("t6_pulses", pulse_cnt[0] - p0, 1);
        chk("t6_araddr_after", last_araddr, 32'h0000_5000);
        chk("t6_rs_valid", last_rsv, 2'b01);
        chk("t6_rdata", last_rsd, 32'h600D_F00D);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

endmodule
`default_nettype wire
